// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, FSM state
// encodings and the mux-select codes driven into the datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational map from FSM state to the datapath control word. The
// memory handshake and the ALU zero flag qualify a few enables, and a low
// reset forces the whole word to zero so nothing leaks out mid-reset.
module mc_output_decoder
  import mips_ctrl_pkg::*;
(
  input  logic       reset_n_i,
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic       instr_done_o,
  output logic       illegal_op_o
);

  // Decode the control word; unlisted outputs and unused codes stay at 0.
  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REGB;
    alu_op_o     = ALUOP_ADD;
    pc_src_o     = PCSRC_ALURES;
    pc_en_o      = 1'b0;
    instr_done_o = 1'b0;
    illegal_op_o = 1'b0;
    if (reset_n_i) begin
      case (state_i)
        S_FETCH: begin
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = mem_ready_i;
          pc_en_o     = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o  = SRCB_IMMSH2;
          illegal_op_o = !op_supported(opcode_i);
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
        end
        S_MEMRD: begin
          iord_o = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEMWR: begin
          iord_o       = 1'b1;
          mem_write_o  = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_dst_o    = 1'b1;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o  = 1'b1;
          alu_op_o     = ALUOP_SUB;
          pc_src_o     = PCSRC_ALUOUT;
          pc_en_o      = zero_i;
          instr_done_o = 1'b1;
        end
        S_ADDIWB: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_JUMP: begin
          pc_src_o     = PCSRC_JUMP;
          pc_en_o      = 1'b1;
          instr_done_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS core. Holds the state register and
// next-state logic; the control word itself comes from mc_output_decoder.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e state_q, state_d;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state logic; memory states hold until the access completes.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_output_decoder u_dec (
    .reset_n_i    (reset_n),
    .state_i      (state_q),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .iord_o       (IorD),
    .mem_write_o  (MemWrite),
    .ir_write_o   (IRWrite),
    .reg_dst_o    (RegDst),
    .mem_to_reg_o (MemtoReg),
    .reg_write_o  (RegWrite),
    .alu_src_a_o  (ALUSrcA),
    .alu_src_b_o  (ALUSrcB),
    .alu_op_o     (ALUop),
    .pc_src_o     (PCSrc),
    .pc_en_o      (pc_en),
    .instr_done_o (instr_done),
    .illegal_op_o (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a cycle-by-cycle vector table
// plus hand-written reset-in-MEMRD and per-instruction latency sequences.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSrc;
  logic       pc_en, instr_done, illegal_op;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUop      (ALUop),
    .PCSrc      (PCSrc),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout:
  // [15]IorD [14]MemWrite [13]IRWrite [12]RegDst [11]MemtoReg [10]RegWrite
  // [9]ALUSrcA [8:7]ALUSrcB [6:5]ALUop [4:3]PCSrc [2]pc_en [1]instr_done [0]illegal_op
  logic [15:0] cw;
  assign cw = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUop, PCSrc, pc_en, instr_done, illegal_op};

  localparam logic [15:0] W_ZERO    = 16'h0000;
  localparam logic [15:0] W_FETCH   = 16'h2084; // IRWrite, SrcB=01, pc_en
  localparam logic [15:0] W_FSTALL  = 16'h0080; // SrcB=01 only
  localparam logic [15:0] W_DECODE  = 16'h0180; // SrcB=11
  localparam logic [15:0] W_ILLEGAL = 16'h0181; // SrcB=11, illegal_op
  localparam logic [15:0] W_MEMADR  = 16'h0300; // SrcA=1, SrcB=10
  localparam logic [15:0] W_MEMRD   = 16'h8000; // IorD
  localparam logic [15:0] W_MEMWB   = 16'h0C02; // MemtoReg, RegWrite, done
  localparam logic [15:0] W_MEMWRS  = 16'hC000; // IorD, MemWrite
  localparam logic [15:0] W_MEMWRD  = 16'hC002; // IorD, MemWrite, done
  localparam logic [15:0] W_EXEC    = 16'h0240; // SrcA=1, ALUop=10
  localparam logic [15:0] W_ALUWB   = 16'h1402; // RegDst, RegWrite, done
  localparam logic [15:0] W_BRT     = 16'h022E; // SrcA, ALUop=01, PCSrc=01, pc_en, done
  localparam logic [15:0] W_BRNT    = 16'h022A; // same without pc_en
  localparam logic [15:0] W_ADDIEX  = 16'h0300;
  localparam logic [15:0] W_ADDIWB  = 16'h0402; // RegWrite, done
  localparam logic [15:0] W_JUMP    = 16'h0016; // PCSrc=10, pc_en, done

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JJ = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [15:0] exp, input string name);
    vec_t v;
    v.rst_n = r; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // From FETCH (at a negedge), run one instruction with mem_ready=1 and
  // report the cycle index of its instr_done pulse and how many pulses came.
  task automatic run_latency(input logic [5:0] op, input logic z,
                             output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      opcode = op; zero = z; mem_ready = 1'b1;
      #2;
      if (instr_done) begin
        pulses++;
        if (lat == 0) lat = c;
      end
      if (lat != 0) break;
      @(negedge clk);
    end
    // The following cycle is the next FETCH: no further pulse expected.
    @(negedge clk);
    #2;
    if (instr_done) pulses++;
  endtask

  initial begin
    int lat, pulses;
    logic [5:0] lat_ops [6];
    int         lat_exp [6];
    reset_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held, then lw / sw / beq / R / addi / j / illegal / stalled lw.
    add(0, LW,  0, 1, W_ZERO,    "reset_c0");
    add(0, LW,  0, 1, W_ZERO,    "reset_c1");
    add(0, LW,  0, 1, W_ZERO,    "reset_c2");
    add(1, LW,  0, 1, W_FETCH,   "lw_fetch");
    add(1, LW,  0, 1, W_DECODE,  "lw_decode");
    add(1, LW,  0, 1, W_MEMADR,  "lw_memadr");
    add(1, LW,  0, 1, W_MEMRD,   "lw_memrd");
    add(1, LW,  0, 1, W_MEMWB,   "lw_memwb");
    add(1, SW,  0, 0, W_FSTALL,  "sw_fetch_stall");
    add(1, SW,  0, 1, W_FETCH,   "sw_fetch");
    add(1, SW,  0, 1, W_DECODE,  "sw_decode");
    add(1, SW,  0, 1, W_MEMADR,  "sw_memadr");
    add(1, SW,  0, 0, W_MEMWRS,  "sw_memwr_stall1");
    add(1, SW,  0, 0, W_MEMWRS,  "sw_memwr_stall2");
    add(1, SW,  0, 1, W_MEMWRD,  "sw_memwr_done");
    add(1, BEQ, 1, 1, W_FETCH,   "beqt_fetch");
    add(1, BEQ, 1, 1, W_DECODE,  "beqt_decode");
    add(1, BEQ, 1, 0, W_BRT,     "beqt_branch");
    add(1, BEQ, 0, 1, W_FETCH,   "beqn_fetch");
    add(1, BEQ, 0, 1, W_DECODE,  "beqn_decode");
    add(1, BEQ, 0, 1, W_BRNT,    "beqn_branch");
    add(1, RT,  0, 1, W_FETCH,   "r_fetch");
    add(1, RT,  0, 1, W_DECODE,  "r_decode");
    add(1, RT,  0, 0, W_EXEC,    "r_exec");
    add(1, RT,  0, 0, W_ALUWB,   "r_aluwb");
    add(1, ADDI,0, 1, W_FETCH,   "addi_fetch");
    add(1, ADDI,0, 1, W_DECODE,  "addi_decode");
    add(1, ADDI,0, 1, W_ADDIEX,  "addi_ex");
    add(1, ADDI,0, 1, W_ADDIWB,  "addi_wb");
    add(1, JJ,  0, 1, W_FETCH,   "j_fetch");
    add(1, JJ,  0, 1, W_DECODE,  "j_decode");
    add(1, JJ,  0, 1, W_JUMP,    "j_jump");
    add(1, BAD, 0, 1, W_FETCH,   "bad_fetch");
    add(1, BAD, 0, 1, W_ILLEGAL, "bad_decode");
    add(1, LW,  0, 1, W_FETCH,   "bad_next_fetch");
    add(1, LW,  0, 1, W_DECODE,  "lw2_decode");
    add(1, LW,  0, 1, W_MEMADR,  "lw2_memadr");
    add(1, LW,  0, 0, W_MEMRD,   "lw2_memrd_stall");
    add(1, LW,  0, 1, W_MEMRD,   "lw2_memrd");
    add(1, LW,  0, 1, W_MEMWB,   "lw2_memwb");
    add(1, LW,  0, 1, W_FETCH,   "lw2_next_fetch");

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_n = vecs[i].rst_n; opcode = vecs[i].op;
      zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #2;
      check(vecs[i].name, cw, vecs[i].exp);
    end

    // Reset asserted in the middle of a MEMRD cycle.
    reset_pulse();
    opcode = LW; zero = 1'b0; mem_ready = 1'b1;
    #2 check("mr_fetch", cw, W_FETCH);
    @(negedge clk); #2 check("mr_decode", cw, W_DECODE);
    @(negedge clk); #2 check("mr_memadr", cw, W_MEMADR);
    @(negedge clk); mem_ready = 1'b0;
    #2 check("mr_memrd", cw, W_MEMRD);
    reset_n = 1'b0;
    #1 check("mr_reset_immediate", cw, W_ZERO);
    mem_ready = 1'b1;
    @(negedge clk); #2 check("mr_reset_held", cw, W_ZERO);
    reset_n = 1'b1;
    #1 check("mr_after_release", cw, W_FETCH);
    @(negedge clk); #2 check("mr_decode_again", cw, W_DECODE);

    // Latency of each instruction class with mem_ready held high.
    lat_ops[0] = LW;   lat_exp[0] = 5;
    lat_ops[1] = SW;   lat_exp[1] = 4;
    lat_ops[2] = RT;   lat_exp[2] = 4;
    lat_ops[3] = ADDI; lat_exp[3] = 4;
    lat_ops[4] = BEQ;  lat_exp[4] = 3;
    lat_ops[5] = JJ;   lat_exp[5] = 3;
    for (int k = 0; k < 6; k++) begin
      reset_pulse();
      run_latency(lat_ops[k], 1'b1, lat, pulses);
      check_int($sformatf("latency_op%b", lat_ops[k]), lat, lat_exp[k]);
      check_int($sformatf("done_pulses_op%b", lat_ops[k]), pulses, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control FSM for the multicycle variant of the MIPS core.
- Sequences the shared ALU, memory, IR, PC and register file over several cycles per instruction.
- Drives `ALUop[1:0]` into the existing ALU decoder, which still turns `ALUop` plus `funct` into `ALU_control`.
- Adds a memory-ready handshake so that fetch and data accesses can stall.

Parameters:
- None. Opcodes and state encodings are fixed constants from the shared package.

Ports:
- `clk` — in, 1 — rising-edge clock.
- `reset_n` — in, 1 — asynchronous, active-low reset.
- `opcode` — in, 6 — `instr[31:26]` from the IR; sampled in DECODE only.
- `zero` — in, 1 — ALU zero flag.
- `mem_ready` — in, 1 — memory accepts/completes the current access this cycle.
- `IorD` — out, 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite` — out, 1 — memory write strobe.
- `IRWrite` — out, 1 — IR load enable.
- `RegDst` — out, 1 — register destination: 0 = rt, 1 = rd.
- `MemtoReg` — out, 1 — writeback source: 0 = ALUOut, 1 = MDR.
- `RegWrite` — out, 1 — register-file write enable.
- `ALUSrcA` — out, 1 — ALU A operand: 0 = PC, 1 = reg A.
- `ALUSrcB` — out, 2 — ALU B operand: 00 = reg B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUop` — out, 2 — 00 = add, 01 = sub, 10 = use funct.
- `PCSrc` — out, 2 — next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pc_en` — out, 1 — PC load enable.
- `instr_done` — out, 1 — one-cycle pulse in the final cycle of each instruction.
- `illegal_op` — out, 1 — one-cycle pulse when DECODE sees an unsupported opcode.

Behaviour:
- State register: 4 bits, Moore outputs decoded from state, plus `mem_ready` qualification where noted.
- Async reset: state = FETCH.
- While `reset_n` = 0, every output is forced to 0:
  - all enables (`MemWrite`, `IRWrite`, `RegWrite`, `pc_en`);
  - `instr_done`, `illegal_op`;
  - all mux selects.
- After `reset_n` deasserts, the first rising edge is evaluated in FETCH.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge, with all outputs 0.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=00, `PCSrc`=00.
  - `IRWrite` = `pc_en` = `mem_ready`.
  - Next state: DECODE if `mem_ready`, else stay in FETCH.
- DECODE:
  - Outputs: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=00 (branch target precompute).
  - Next state by opcode: lw 100011 or sw 101011 → MEMADR; R-type 000000 → EXEC; beq 000100 → BRANCH; addi 001000 → ADDIEX; j 000010 → JUMP.
  - Any other opcode → FETCH, with `illegal_op`=1 this cycle.
- MEMADR:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00.
  - Next state: MEMRD if lw, MEMWR if sw. The opcode is re-read; the IR is stable.
- MEMRD:
  - Outputs: `IorD`=1.
  - Next state: MEMWB if `mem_ready`, else stay.
- MEMWB:
  - Outputs: `RegDst`=0, `MemtoReg`=1, `RegWrite`=1, `instr_done`=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: `IorD`=1, `MemWrite`=1. `MemWrite` stays high for every stall cycle.
  - `instr_done` = `mem_ready`.
  - Next state: FETCH if `mem_ready`, else stay.
- EXEC:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: `RegDst`=1, `MemtoReg`=0, `RegWrite`=1, `instr_done`=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=01, `PCSrc`=01.
  - `pc_en` = `zero`.
  - `instr_done`=1.
  - Next state: FETCH.
- ADDIEX:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00.
  - Next state: ADDIWB.
- ADDIWB:
  - Outputs: `RegDst`=0, `MemtoReg`=0, `RegWrite`=1, `instr_done`=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: `PCSrc`=10, `pc_en`=1, `instr_done`=1.
  - Next state: FETCH.
- Latency with `mem_ready` held at 1 (cycles including FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset mid-instruction: the state is abandoned immediately. No partial `RegWrite`/`MemWrite` is issued after reset assertion.
- `mem_ready` is ignored in states that do not access memory.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - 4-bit state typedef/localparams;
  - ALUop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - ALUSrcB and PCSrc select constants.
- One sub-module, `mc_output_decoder`: combinational state → control-word map, with `mem_ready`, `zero` and reset gating.
- Next-state logic and the state register stay in `multicycle_control_fsm`.

Test Plan:
1. Reset: `reset_n`=0 for 3 cycles, `mem_ready`=1 → all outputs 0. After release, FETCH with `IRWrite`=1, `pc_en`=1, `ALUSrcB`=01.
2. lw 100011 with `mem_ready`=1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB. `RegWrite`=1 with `MemtoReg`=1 on cycle 5; `instr_done` pulses exactly once.
3. sw 101011 with `mem_ready` low for 2 cycles in MEMWR → `MemWrite`=1 for 3 consecutive cycles, `instr_done` only on the third, then FETCH.
4. beq 000100: with `zero`=1 → BRANCH has `pc_en`=1, `PCSrc`=01, `ALUop`=01. With `zero`=0 → `pc_en`=0. Both take 3 cycles.
5. R-type 000000 → EXEC has `ALUop`=10; ALUWB has `RegDst`=1, `RegWrite`=1. addi 001000 → ADDIWB has `RegDst`=0. j 000010 → JUMP has `PCSrc`=10, `pc_en`=1.
6. Opcode 111111 → `illegal_op`=1 in DECODE, next state FETCH, no `RegWrite`/`MemWrite`. Separately, `reset_n`=0 asserted in MEMRD → all outputs 0 immediately, then FETCH after release.
